router_out_fifo: RTL and testbench

- Per-destination output buffer of the 1x3 router. One instance per output port, three in total.
- Sits between the router's input-side register/FSM (write side) and the destination port (data_out/vld_out/read_enb).
- Stores header, payload and parity bytes with a header tag. Tracks packet boundaries on the read side.
- Flushes itself (soft reset) when the destination ignores valid data for TIMEOUT consecutive cycles.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_out_timer.sv | 45 ++++
 rtl/router_out_fifo.sv | 105 ++++++++++
 tb/tb_router_out_fifo.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router output-side buffers.
// Header byte layout: [7:2] payload length, [1:0] destination address.
package router_pkg;

    localparam int DATA_W          = 8;
    localparam int HDR_LEN_MSB     = 7;
    localparam int HDR_LEN_LSB     = 2;
    localparam int HDR_ADDR_MSB    = 1;
    localparam int HDR_ADDR_LSB    = 0;
    localparam int PKT_CNT_W       = 7;
    localparam int DEFAULT_TIMEOUT = 30;

    typedef struct packed {
        logic              lfd;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    // Bytes still to come after a header: payload length plus the parity byte.
    function automatic logic [PKT_CNT_W-1:0] hdr_pkt_len(input logic [DATA_W-1:0] hdr);
        return {1'b0, hdr[HDR_LEN_MSB:HDR_LEN_LSB]} + PKT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_out_timer.sv
// Counts consecutive cycles of valid-but-unread data; flush is combinational on the
// expiring edge, soft_reset is its registered one-cycle echo. No backpressure.
module router_out_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic resetn,
    input  logic vld_out,
    input  logic read_enb,
    output logic flush,
    output logic soft_reset
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          soft_reset_q;
    logic          stall;

    assign stall = vld_out & ~read_enb;
    assign flush = stall && (timer_q == LAST);

    always_comb begin
        timer_d = '0;
        if (stall && !flush) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timer_q      <= '0;
            soft_reset_q <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            soft_reset_q <= flush;
        end
    end

    assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_out_fifo.sv
// Per-destination byte FIFO with header tags and packet-end marking; read data 1 cycle after
// the accepting edge. Writes dropped while full or on a timeout flush; reads ignored while empty.
module router_out_fifo
    import router_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              write_enb,
    input  logic [DATA_W-1:0] data_in,
    input  logic              lfd_state,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              data_last,
    output logic              vld_out,
    output logic              full,
    output logic              empty,
    output logic              soft_reset
);

    localparam int AW = $clog2(DEPTH);

    fifo_entry_t           mem_q [DEPTH];
    fifo_entry_t           rd_entry;
    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PKT_CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [DATA_W-1:0]     data_out_q, data_out_d;
    logic                  data_last_q, data_last_d;
    logic                  flush, wr_acc, rd_acc;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign vld_out  = ~empty;
    assign wr_acc   = write_enb && !full && !flush;
    assign rd_acc   = read_enb && !empty;
    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

    router_out_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock      (clock),
        .resetn     (resetn),
        .vld_out    (vld_out),
        .read_enb   (read_enb),
        .flush      (flush),
        .soft_reset (soft_reset)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_cnt_d   = pkt_cnt_q;
        data_out_d  = data_out_q;
        data_last_d = data_last_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            pkt_cnt_d   = '0;
            data_out_d  = '0;
            data_last_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (rd_acc) begin
                rd_ptr_d    = rd_ptr_q + (AW+1)'(1);
                data_out_d  = rd_entry.data;
                data_last_d = 1'b0;
                if (rd_entry.lfd) begin
                    pkt_cnt_d = hdr_pkt_len(rd_entry.data);
                end else if (pkt_cnt_q != '0) begin
                    // Orphan bytes (count already zero) pass through unmarked.
                    pkt_cnt_d   = pkt_cnt_q - PKT_CNT_W'(1);
                    data_last_d = (pkt_cnt_q == PKT_CNT_W'(1));
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_cnt_q   <= '0;
            data_out_q  <= '0;
            data_last_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            data_out_q  <= data_out_d;
            data_last_q <= data_last_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{lfd: lfd_state, data: data_in};
        end
    end

    assign data_out  = data_out_q;
    assign data_last = data_last_q;

endmodule

// File: tb/tb_router_out_fifo.sv
// Bench for router_out_fifo: table vectors, directed corner sequences and random traffic
// compared against a queue-based reference model.
module tb_router_out_fifo;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       write_enb = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       lfd_state = 1'b0;
    logic       read_enb = 1'b0;
    logic [7:0] data_out;
    logic       data_last, vld_out, full, empty, soft_reset;

    router_out_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .write_enb  (write_enb),
        .data_in    (data_in),
        .lfd_state  (lfd_state),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .data_last  (data_last),
        .vld_out    (vld_out),
        .full       (full),
        .empty      (empty),
        .soft_reset (soft_reset)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a queue of {lfd,data}, bytes-remaining count, run of unread-valid cycles.
    logic [8:0] mq[$];
    int         m_remain;
    int         m_idle;
    logic [7:0] m_dout;
    logic       m_last;
    logic       m_sr;

    task automatic model_reset();
        mq.delete();
        m_remain = 0;
        m_idle   = 0;
        m_dout   = 8'h00;
        m_last   = 1'b0;
        m_sr     = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [7:0] din, input logic lfd, input logic re);
        bit         was_empty, was_full;
        logic [8:0] e;
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() == DEPTH);
        if (!was_empty && !re && m_idle == TIMEOUT - 1) begin
            model_reset();
            m_sr = 1'b1;
        end else begin
            m_sr   = 1'b0;
            m_idle = (!was_empty && !re) ? m_idle + 1 : 0;
            if (re && !was_empty) begin
                e      = mq.pop_front();
                m_dout = e[7:0];
                m_last = 1'b0;
                if (e[8]) begin
                    m_remain = int'(e[7:2]) + 1;
                end else if (m_remain > 0) begin
                    m_last   = (m_remain == 1);
                    m_remain = m_remain - 1;
                end
            end
            if (we && !was_full) mq.push_back({lfd, din});
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("data_out",   32'(data_out),   32'(m_dout));
        chk("data_last",  32'(data_last),  32'(m_last));
        chk("vld_out",    32'(vld_out),    32'(mq.size() != 0));
        chk("empty",      32'(empty),      32'(mq.size() == 0));
        chk("full",       32'(full),       32'(mq.size() == DEPTH));
        chk("soft_reset", 32'(soft_reset), 32'(m_sr));
    endtask

    task automatic step(input logic we, input logic [7:0] din, input logic lfd, input logic re);
        write_enb = we;
        data_in   = din;
        lfd_state = lfd;
        read_enb  = re;
        @(posedge clock);
        #1;
        model_edge(we, din, lfd, re);
        chk_model();
    endtask

    typedef struct {
        logic       we;
        logic [7:0] din;
        logic       lfd;
        logic       re;
        logic [7:0] e_dout;
        logic       e_last;
        logic       e_empty;
        logic       e_full;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [7:0] held;
        logic [7:0] b;

        tbl[0]  = '{1'b1, 8'h0D, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h3F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h0D, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3F, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3F, 1'b1, 1'b1, 1'b0};

        // Reset state
        model_reset();
        #3;
        chk_model();
        repeat (2) @(posedge clock);
        #1 resetn = 1'b1;

        // 1: basic packet through the table
        foreach (tbl[i]) begin
            step(tbl[i].we, tbl[i].din, tbl[i].lfd, tbl[i].re);
            chk("t1_dout",  32'(data_out),  32'(tbl[i].e_dout));
            chk("t1_last",  32'(data_last), 32'(tbl[i].e_last));
            chk("t1_empty", 32'(empty),     32'(tbl[i].e_empty));
            chk("t1_full",  32'(full),      32'(tbl[i].e_full));
        end

        // 2: fill, drop the overflow byte, drain in order
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i * 7 + 1), 1'b0, 1'b0);
        chk("t2_full", 32'(full), 32'd1);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b1);
            chk("t2_order", 32'(data_out), 32'(8'(i * 7 + 1)));
        end
        chk("t2_empty", 32'(empty), 32'd1);

        // 3: simultaneous read+write at full, then at empty
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b1);
        chk("t3_full_drop", 32'(full), 32'd0);
        chk("t3_rd", 32'(data_out), 32'h80);
        for (int i = 1; i < DEPTH; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        held = data_out;
        step(1'b1, 8'hA5, 1'b0, 1'b1);
        chk("t3_empty_wr", 32'(empty), 32'd0);
        chk("t3_dout_hold", 32'(data_out), 32'(held));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t3_rd_a5", 32'(data_out), 32'hA5);

        // 4: timeout flush, then a read at cycle 29 that prevents it
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            chk("t4_sr_pulse", 32'(soft_reset), 32'(k == TIMEOUT));
        end
        chk("t4_vld", 32'(vld_out), 32'd0);
        chk("t4_dout", 32'(data_out), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t4_sr_one", 32'(soft_reset), 32'd0);
        step(1'b1, 8'h6B, 1'b0, 1'b0);
        for (int k = 1; k < TIMEOUT - 1; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t4_saved", 32'(data_out), 32'h6B);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            chk("t4_no_sr", 32'(soft_reset), 32'd0);
        end

        // 5: 40 write/read pairs wrap the pointers
        for (int i = 0; i < 40; i++) begin
            b = 8'($urandom);
            step(1'b1, b, 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b1);
            chk("t5_byte", 32'(data_out), 32'(b));
            chk("t5_nofull", 32'(full), 32'd0);
        end

        // 6: async reset mid-packet, then a fresh packet
        step(1'b1, 8'h0D, 1'b1, 1'b0);
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b0);
        step(1'b1, 8'hCF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        write_enb = 1'b0;
        read_enb  = 1'b0;
        #2 resetn = 1'b0;
        #1;
        model_reset();
        chk_model();
        @(posedge clock);
        #1 resetn = 1'b1;
        step(1'b1, 8'h05, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b1, 8'h12, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t6_not_last", 32'(data_last), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t6_last", 32'(data_last), 32'd1);
        chk("t6_parity", 32'(data_out), 32'h12);

        // Random traffic with periodic read starvation to provoke flushes
        for (int i = 0; i < 600; i++) begin
            logic re;
            if ((i % 150) >= 110) re = 1'b0;
            else re = ($urandom_range(0, 2) != 0);
            step(1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0), re);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
